// File: rtl/zap_branch_predict_btb.sv
// Branch target buffer with a fetch-stage pipeline register.
// Lookup is combinational on i_pc; the result is registered with the fetched instruction.
module zap_branch_predict_btb #(
  parameter int ENTRIES   = 512,
  parameter int CTR_WIDTH = 2,
  parameter int TAG_WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_decode,
  input  logic        i_clear_from_decode,
  input  logic        i_invalidate,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic        i_val,
  input  logic        i_abt,
  input  logic [31:0] i_pc_plus_8,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  output logic [31:0] o_inst_ff,
  output logic        o_val_ff,
  output logic        o_abt_ff,
  output logic [31:0] o_pc_plus_8_ff,
  output logic [31:0] o_pc_ff,
  output logic        o_taken_ff,
  output logic [31:0] o_target_ff,
  output logic        o_hit_ff
);

  localparam int IW = $clog2(ENTRIES);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(1 << (CTR_WIDTH - 1));

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_q    [ENTRIES];

  logic [IW-1:0]        rd_idx;
  logic [TAG_WIDTH-1:0] rd_tag;
  logic                 rd_hit;
  logic                 rd_taken;
  logic [31:0]          rd_target;

  logic [IW-1:0]        up_idx;
  logic [TAG_WIDTH-1:0] up_tag;
  logic                 up_hit;
  logic                 up_en;
  logic [CTR_WIDTH-1:0] ctr_next;

  logic clear_pipe;
  logic hold_pipe;

  // Bit 0 and the bits above the tag never take part in indexing or matching.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_pc, i_upd_pc};

  // Halfword-granular index so ARM and Thumb branches share one table.
  assign rd_idx    = i_pc[IW:1];
  assign rd_tag    = i_pc[IW+TAG_WIDTH:IW+1];
  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken  = rd_hit && ctr_q[rd_idx][CTR_WIDTH-1];
  assign rd_target = rd_hit ? target_q[rd_idx] : 32'd0;

  assign up_idx = i_upd_pc[IW:1];
  assign up_tag = i_upd_pc[IW+TAG_WIDTH:IW+1];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en  = i_upd_valid && !i_data_stall && !i_invalidate && !i_reset;

  always_comb begin
    ctr_next = ctr_q[up_idx];
    if (i_upd_taken) begin
      if (ctr_q[up_idx] != CTR_MAX) ctr_next = ctr_q[up_idx] + 1'b1;
    end else if (ctr_q[up_idx] != '0) begin
      ctr_next = ctr_q[up_idx] - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else if (i_invalidate) begin
      valid_q <= '0;
    end else if (up_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next;
      end else if (i_upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= CTR_INIT;
      end
    end
  end

  // Tags and targets carry no reset; valid bits alone qualify them.
  always_ff @(posedge i_clk) begin
    if (up_en && i_upd_taken) begin
      target_q[up_idx] <= i_upd_target;
      if (!up_hit) tag_q[up_idx] <= up_tag;
    end
  end

  always_comb begin
    clear_pipe = 1'b0;
    hold_pipe  = 1'b0;
    if (i_reset || i_clear_from_writeback)                                   clear_pipe = 1'b1;
    else if (i_data_stall)                                                   hold_pipe  = 1'b1;
    else if (i_clear_from_alu)                                               clear_pipe = 1'b1;
    else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) hold_pipe = 1'b1;
    else if (i_clear_from_decode)                                            clear_pipe = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (clear_pipe) begin
      o_inst_ff      <= 32'd0;
      o_val_ff       <= 1'b0;
      o_abt_ff       <= 1'b0;
      o_pc_plus_8_ff <= 32'd8;
      o_pc_ff        <= 32'd0;
      o_taken_ff     <= 1'b0;
      o_target_ff    <= 32'd0;
      o_hit_ff       <= 1'b0;
    end else if (!hold_pipe) begin
      o_inst_ff      <= i_inst;
      o_val_ff       <= i_val;
      o_abt_ff       <= i_abt;
      o_pc_plus_8_ff <= i_pc_plus_8;
      o_pc_ff        <= i_pc;
      o_taken_ff     <= rd_taken;
      o_target_ff    <= rd_target;
      o_hit_ff       <= rd_hit;
    end
  end

endmodule
